// File: rtl/spi_job_arbiter.sv
// Round-robin arbiter that hands two requesters' SPI jobs to one serial-out engine.
// Optional RUN-phase watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_job_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int LEN_W       = 8,
  parameter int LOAD_CYC    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [LEN_W-1:0]  LEN0,
  input  logic [LEN_W-1:0]  LEN1,
  input  logic [7:0]        DIV0,
  input  logic [7:0]        DIV1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              SPI_BGN,
  output logic [ADDR_W-1:0] SPI_ADDR_BGN,
  output logic [LEN_W-1:0]  SPI_DATA_LEN,
  output logic [7:0]        SPI_FREQ_DIV,
  input  logic              SPI_DONE,
  output logic              BUSY,
  output logic              GNT_ID,
  output logic              ERR
);

  localparam int LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [LCW-1:0]   r_loadCnt;
  logic             r_lastGnt;
  logic             w_grantReq;
  logic             w_grantId;
  logic             w_timeout;

  // The requester not served last wins a tie; a lone request always wins.
  always_comb begin
    w_grantReq = REQ0 | REQ1;
    w_grantId  = (REQ0 && REQ1) ? ~r_lastGnt : REQ1;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] r_runCnt;

  assign w_timeout = (r_runCnt == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_runCnt <= '0;
    end else if (r_state != S_RUN) begin
      r_runCnt <= '0;
    end else begin
      r_runCnt <= r_runCnt + TCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR <= 1'b0;
    end else begin
      ERR <= (r_state == S_RUN) && !SPI_DONE && w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign ERR       = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: if (w_grantReq) w_nextState = S_LOAD;
      S_LOAD: if (r_loadCnt == LCW'(LOAD_CYC - 1)) w_nextState = S_RUN;
      S_RUN:  if (SPI_DONE || w_timeout) w_nextState = S_DONE;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Every output is registered from the next state so the engine sees glitch-free levels.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_loadCnt    <= '0;
      r_lastGnt    <= 1'b1;
      GNT_ID       <= 1'b0;
      SPI_ADDR_BGN <= '0;
      SPI_DATA_LEN <= '0;
      SPI_FREQ_DIV <= '0;
      SPI_BGN      <= 1'b0;
      BUSY         <= 1'b0;
      ACK0         <= 1'b0;
      ACK1         <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_loadCnt <= (r_state == S_LOAD) ? r_loadCnt + LCW'(1) : '0;
      SPI_BGN   <= (w_nextState == S_RUN);
      BUSY      <= (w_nextState != S_IDLE);
      ACK0      <= (w_nextState == S_DONE) && !GNT_ID;
      ACK1      <= (w_nextState == S_DONE) && GNT_ID;
      if (r_state == S_IDLE && w_grantReq) begin
        GNT_ID       <= w_grantId;
        r_lastGnt    <= w_grantId;
        SPI_ADDR_BGN <= w_grantId ? ADDR1 : ADDR0;
        SPI_DATA_LEN <= w_grantId ? LEN1 : LEN0;
        SPI_FREQ_DIV <= w_grantId ? DIV1 : DIV0;
      end
    end
  end

endmodule

// File: tb/tb_spi_job_arbiter.sv
// Self-checking bench for spi_job_arbiter: directed scenarios plus randomized jobs
// checked against a round-robin reference model and a behavioural SPI engine.
module tb_spi_job_arbiter;

  localparam int ADDR_W   = 9;
  localparam int LEN_W    = 8;
  localparam int LOAD_CYC = 2;
  localparam int TO       = 16;

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b1;
  logic              REQ0  = 1'b0;
  logic              REQ1  = 1'b0;
  logic [ADDR_W-1:0] ADDR0 = '0;
  logic [ADDR_W-1:0] ADDR1 = '0;
  logic [LEN_W-1:0]  LEN0  = '0;
  logic [LEN_W-1:0]  LEN1  = '0;
  logic [7:0]        DIV0  = '0;
  logic [7:0]        DIV1  = '0;
  logic              ACK0, ACK1, SPI_BGN, SPI_DONE, BUSY, GNT_ID, ERR;
  logic [ADDR_W-1:0] SPI_ADDR_BGN;
  logic [LEN_W-1:0]  SPI_DATA_LEN;
  logic [7:0]        SPI_FREQ_DIV;

  logic doneForce = 1'b0;
  int   engLat    = 1000000;
  int   engCnt    = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  logic refLast   = 1'b1;

  spi_job_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LOAD_CYC(LOAD_CYC), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .LEN0(LEN0), .LEN1(LEN1),
    .DIV0(DIV0), .DIV1(DIV1), .ACK0(ACK0), .ACK1(ACK1),
    .SPI_BGN(SPI_BGN), .SPI_ADDR_BGN(SPI_ADDR_BGN), .SPI_DATA_LEN(SPI_DATA_LEN),
    .SPI_FREQ_DIV(SPI_FREQ_DIV), .SPI_DONE(SPI_DONE),
    .BUSY(BUSY), .GNT_ID(GNT_ID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Engine model: raises DONE in the engLat-th cycle that BGN is high.
  always @(posedge CLK) engCnt <= SPI_BGN ? engCnt + 1 : 0;
  assign SPI_DONE = doneForce | (SPI_BGN && (engCnt == engLat - 1));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Round robin: scan requesters starting after the one served last.
  function automatic logic pickGnt(input logic r0, input logic r1, input logic last);
    logic [1:0] req;
    int idx;
    req = {r1, r0};
    for (int k = 1; k <= 2; k++) begin
      idx = (int'(last) + k) % 2;
      if (req[idx]) return idx[0];
    end
    return 1'b0;
  endfunction

  // mode: 0 plain, 1 ADDR0 -> 1FF mid-run, 2 scramble all params mid-run, 3 DONE forced during LOAD.
  task automatic applyStimulus(input logic expGnt, input logic [ADDR_W-1:0] eA,
                               input logic [LEN_W-1:0] eL, input logic [7:0] eD,
                               input int lat, input int mode, input logic dropReq);
    int   n, lowCnt, highCnt, expHigh;
    logic expErr, moved, ackEarly;
    expHigh = lat;
    expErr  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    if (lat > TO) begin
      expHigh = TO;
      expErr  = 1'b1;
    end
`endif
    engLat = lat;
    n = 0;
    @(negedge CLK);
    while (!BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("grant_busy", 32'(BUSY), 32'd1);
    checkOutput("grant_id", 32'(GNT_ID), 32'(expGnt));
    checkOutput("grant_addr", 32'(SPI_ADDR_BGN), 32'(eA));
    checkOutput("grant_len", 32'(SPI_DATA_LEN), 32'(eL));
    checkOutput("grant_div", 32'(SPI_FREQ_DIV), 32'(eD));
    lowCnt = 0;
    ackEarly = 1'b0;
    while (BUSY && !SPI_BGN && lowCnt < 50) begin
      if (ACK0 || ACK1) ackEarly = 1'b1;
      doneForce = (mode == 3);
      lowCnt++;
      @(negedge CLK);
    end
    doneForce = 1'b0;
    checkOutput("load_cycles", 32'(lowCnt), 32'(LOAD_CYC));
    highCnt = 0;
    moved = 1'b0;
    while (SPI_BGN && highCnt < 300) begin
      if (SPI_ADDR_BGN !== eA || SPI_DATA_LEN !== eL || SPI_FREQ_DIV !== eD) moved = 1'b1;
      if (ACK0 || ACK1) ackEarly = 1'b1;
      if (highCnt == 2 && mode == 1) ADDR0 = 9'h1FF;
      if (highCnt == 2 && mode == 2) begin
        ADDR0 = 9'($urandom); ADDR1 = 9'($urandom);
        LEN0 = 8'($urandom); LEN1 = 8'($urandom);
        DIV0 = 8'($urandom); DIV1 = 8'($urandom);
      end
      highCnt++;
      @(negedge CLK);
    end
    checkOutput("run_cycles", 32'(highCnt), 32'(expHigh));
    checkOutput("params_held", 32'(moved), 32'd0);
    checkOutput("no_early_ack", 32'(ackEarly), 32'd0);
    checkOutput("done_ack0", 32'(ACK0), 32'(!expGnt));
    checkOutput("done_ack1", 32'(ACK1), 32'(expGnt));
    checkOutput("done_err", 32'(ERR), 32'(expErr));
    checkOutput("done_busy", 32'(BUSY), 32'd1);
    if (dropReq) begin
      if (expGnt) REQ1 = 1'b0;
      else REQ0 = 1'b0;
    end
    @(negedge CLK);
    checkOutput("idle_ack0", 32'(ACK0), 32'd0);
    checkOutput("idle_ack1", 32'(ACK1), 32'd0);
    checkOutput("idle_busy", 32'(BUSY), 32'd0);
    checkOutput("idle_err", 32'(ERR), 32'd0);
    checkOutput("idle_addr_kept", 32'(SPI_ADDR_BGN), 32'(eA));
    refLast = expGnt;
  endtask

  initial begin
    int n;
    logic flag, g;
    logic [ADDR_W-1:0] eA;
    logic [LEN_W-1:0]  eL;
    logic [7:0]        eD;
    int lat, mode;

    #1 RST_N = 1'b0;
    #1;
    checkOutput("rst_bgn", 32'(SPI_BGN), 32'd0);
    checkOutput("rst_ack0", 32'(ACK0), 32'd0);
    checkOutput("rst_ack1", 32'(ACK1), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_err", 32'(ERR), 32'd0);
    checkOutput("rst_gnt", 32'(GNT_ID), 32'd0);
    checkOutput("rst_addr", 32'(SPI_ADDR_BGN), 32'd0);
    checkOutput("rst_len", 32'(SPI_DATA_LEN), 32'd0);
    checkOutput("rst_div", 32'(SPI_FREQ_DIV), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // DONE asserted in IDLE with no requests must be ignored.
    doneForce = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (BUSY || ACK0 || ACK1 || SPI_BGN) flag = 1'b1;
    end
    doneForce = 1'b0;
    @(negedge CLK);
    checkOutput("idle_done_ignored", 32'(flag | BUSY), 32'd0);

    // Both requesters held high for three jobs: grants 0,1,0.
    ADDR0 = 9'h010; LEN0 = 8'd3; DIV0 = 8'd4;
    ADDR1 = 9'h0A5; LEN1 = 8'd7; DIV1 = 8'd2;
    REQ0 = 1'b1; REQ1 = 1'b1;
    applyStimulus(1'b0, 9'h010, 8'd3, 8'd4, 5, 0, 1'b0);
    applyStimulus(1'b1, 9'h0A5, 8'd7, 8'd2, 6, 0, 1'b0);
    applyStimulus(1'b0, 9'h010, 8'd3, 8'd4, 4, 0, 1'b0);
    REQ0 = 1'b0; REQ1 = 1'b0;

    // Basic job with a 40-cycle engine.
    REQ0 = 1'b1;
    applyStimulus(1'b0, 9'h010, 8'd3, 8'd4, 40, 0, 1'b1);

    // ADDR0 changed mid-run is ignored until the next grant picks it up.
    REQ0 = 1'b1;
    applyStimulus(1'b0, 9'h010, 8'd3, 8'd4, 10, 1, 1'b1);
    REQ0 = 1'b1;
    applyStimulus(1'b0, 9'h1FF, 8'd3, 8'd4, 3, 0, 1'b1);
    ADDR0 = 9'h010;

    // LEN=0 passthrough, and DONE forced during LOAD is ignored.
    LEN0 = 8'd0;
    REQ0 = 1'b1;
    applyStimulus(1'b0, 9'h010, 8'd0, 8'd4, 6, 3, 1'b1);
    LEN0 = 8'd3;

    // Reset pulse mid-run aborts the job; the pending REQ0 is granted again.
    REQ0 = 1'b1;
    engLat = 1000000;
    n = 0;
    while (!SPI_BGN && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("rst_run_reached", 32'(SPI_BGN), 32'd1);
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checkOutput("midrst_bgn", 32'(SPI_BGN), 32'd0);
    checkOutput("midrst_busy", 32'(BUSY), 32'd0);
    checkOutput("midrst_ack", 32'(ACK0 | ACK1), 32'd0);
    checkOutput("midrst_addr", 32'(SPI_ADDR_BGN), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    refLast = 1'b1;
    applyStimulus(1'b0, 9'h010, 8'd3, 8'd4, 4, 0, 1'b1);

    // Engine never finishes.
`ifdef SPI_ARB_TIMEOUT_EN
    REQ0 = 1'b1;
    applyStimulus(1'b0, 9'h010, 8'd3, 8'd4, 1000000, 0, 1'b1);
`else
    REQ0 = 1'b1;
    engLat = 1000000;
    repeat (3) @(negedge CLK);
    flag = 1'b0;
    repeat (200) begin
      @(negedge CLK);
      if (!BUSY || ACK0 || ACK1 || ERR) flag = 1'b1;
    end
    checkOutput("no_timeout_hold", 32'(flag), 32'd0);
    REQ0 = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    refLast = 1'b1;
`endif

    // Randomized jobs against the round-robin model.
    repeat (25) begin
      REQ0 = 1'($urandom);
      REQ1 = 1'($urandom);
      if (!REQ0 && !REQ1) REQ0 = 1'b1;
      ADDR0 = 9'($urandom); ADDR1 = 9'($urandom);
      LEN0 = 8'($urandom);  LEN1 = 8'($urandom);
      DIV0 = 8'($urandom);  DIV1 = 8'($urandom);
      g  = pickGnt(REQ0, REQ1, refLast);
      eA = g ? ADDR1 : ADDR0;
      eL = g ? LEN1 : LEN0;
      eD = g ? DIV1 : DIV0;
      lat  = int'($urandom_range(12, 1));
      mode = ($urandom_range(2, 0) == 0) ? 2 : 0;
      applyStimulus(g, eA, eL, eD, lat, mode, 1'b1);
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
